obuf8_bus_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 8-bit output pin bus driven through the 8-bit output buffer module.
- Up to N_REQ internal requesters each stream byte bursts over a valid/ready handshake.
- The block grants one requester at a time, presents each byte on the pins for HOLD cycles with a one-cycle strobe, inserts GAP idle cycles between bursts, and aborts stalled bursts.
- Sits between the stend control logic and the output buffer instance.

---
 rtl/obuf8_bus_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/obuf8_bus_arbiter.sv
// Round-robin arbiter/sequencer driving the shared 8-bit output buffer pins.
// Latency: grant 1 cycle after req_valid; byte on o_data 1 cycle after valid&ready.
// Backpressure: only the owner sees req_ready, and only in SEND; a stalled owner is aborted after TIMEOUT cycles.
// Ports: clk/rst (sync, active-high); req_valid/req_data/req_last/req_ready per requester
//        (requester i uses req_data[8i+7:8i]); grant/owner identify the burst owner;
//        o_data/o_stb feed the output buffer; busy = not IDLE; timeout_err pulses on abort.
module obuf8_bus_arbiter #(
  parameter int         N_REQ    = 4,
  parameter int         HOLD     = 4,
  parameter int         GAP      = 2,
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] IDLE_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         owner,
  output logic [7:0]         o_data,
  output logic               o_stb,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_GAP} state_t;

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_INIT  = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [2:0]       rr_q, rr_d;
  logic [7:0]       data_q, data_d;
  logic             stb_q, stb_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             last_q, last_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             terr_q, terr_d;

  // Arbitration and owner-side muxes
  logic [N_REQ-1:0] above_rr;
  logic [N_REQ-1:0] cand;
  logic [2:0]       pick;
  logic             own_vld;
  logic             own_last;
  logic [7:0]       own_dat;

  always_comb begin
    // Search from the RR pointer upward first; fall back to the full vector
    // for the wrap-around part. Lowest index of the chosen vector wins.
    for (int i = 0; i < N_REQ; i++) begin
      above_rr[i] = (3'(i) >= rr_q);
    end
    cand = req_valid & above_rr;
    if (cand == '0) begin
      cand = req_valid;
    end
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) pick = 3'(i);
    end

    own_vld  = 1'b0;
    own_last = 1'b0;
    own_dat  = IDLE_VAL;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == owner_q) begin
        own_vld  = req_valid[i];
        own_last = req_last[i];
        own_dat  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    data_d    = data_q;
    stb_d     = 1'b0;
    hold_d    = hold_q;
    last_d    = last_q;
    stall_d   = stall_q;
    gap_d     = gap_q;
    terr_d    = 1'b0;
    req_ready = '0;

    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d = S_SEND;
          owner_d = pick;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          rr_d    = (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
          stall_d = '0;
        end
      end

      S_SEND: begin
        // grant_q is the one-hot owner, so it doubles as the ready vector.
        req_ready = grant_q;
        if (own_vld) begin
          state_d = S_HOLD;
          data_d  = own_dat;
          stb_d   = 1'b1;
          hold_d  = HOLD_INIT;
          last_d  = own_last;
          stall_d = '0;
        end else if (stall_q == STALL_MAX) begin
          terr_d  = 1'b1;
          stall_d = '0;
          grant_d = '0;
          data_d  = IDLE_VAL;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end

      S_HOLD: begin
        if (hold_q == '0) begin
          // Pins return to idle between bytes (SEND) as well as after the burst.
          data_d = IDLE_VAL;
          if (last_q) begin
            grant_d = '0;
            if (GAP > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_INIT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_SEND;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      data_q  <= IDLE_VAL;
      stb_q   <= 1'b0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      stall_q <= '0;
      gap_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
      terr_q  <= terr_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign o_data      = data_q;
  assign o_stb       = stb_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule
